// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// ----------------
// Oversampling UART receiver with a show-ahead output FIFO.
//
// Each bit is sampled at its midpoint. Start and stop bits are checked, and
// optionally a parity bit. Good words go into a DEPTH-entry FIFO, and the
// consumer drains it through a valid/ready handshake.
//
// Build option: define UART_RX_PARITY_EN to expect one parity bit between the
// data bits and the stop bit. PARITY_ODD selects odd (1) or even (0) parity.
// Without the macro, parity_error is always 0.
//
// Ports:
//   clock          in   single clock, posedge
//   resetn         in   synchronous active-low reset
//   rx             in   asynchronous serial line, idle high
//   out_data       out  head-of-FIFO word, LSB = first bit received
//   out_valid      out  FIFO non-empty
//   out_ready      in   consumer accepts out_data this cycle
//   level          out  FIFO occupancy
//   frame_error    out  1-cycle pulse, stop bit sampled 0
//   parity_error   out  1-cycle pulse, parity mismatch
//   overrun_error  out  1-cycle pulse, good frame dropped because FIFO full
module uart_rx_buffered #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   rx,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_error,
  output logic                   parity_error,
  output logic                   overrun_error
);

  localparam int TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF  = TICKS / 2;
  localparam int CW    = $clog2(TICKS);
  localparam int IW    = $clog2(WIDTH);
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TICKS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Expected parity bit for a data word
  function automatic logic parity_expected(input logic [WIDTH-1:0] d);
    logic odd;
    odd = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    return (^d) ^ odd;
  endfunction

  logic             sync1_r, sync2_r;
  logic             rx_s;
  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] shreg_r;
  logic             frame_error_r, parity_error_r, overrun_r;
  logic             sample_s, par_bad_s, push_s, pop_s, full_s, accept_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]    level_r;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_r;
`endif

  assign rx_s     = sync2_r;
  assign sample_s = (cnt_r == {CW{1'b0}});

`ifdef UART_RX_PARITY_EN
  assign par_bad_s = par_bad_r;
`else
  assign par_bad_s = 1'b0;
`endif

  // A word is pushed only on a good stop bit with no parity mismatch
  assign push_s   = (state_r == STOP) && sample_s && rx_s && !par_bad_s;
  assign pop_s    = out_valid && out_ready;
  assign full_s   = (level_r == LVL_FULL);
  assign accept_s = push_s && (!full_s || pop_s);

  // Two-flop synchroniser on the asynchronous serial line
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  // Receive FSM: counts down to each mid-bit sample point
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r        <= IDLE;
      cnt_r          <= {CW{1'b0}};
      idx_r          <= {IW{1'b0}};
      shreg_r        <= {WIDTH{1'b0}};
      frame_error_r  <= 1'b0;
      parity_error_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r      <= 1'b0;
`endif
    end else begin
      frame_error_r  <= 1'b0;
      parity_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            cnt_r   <= CNT_HALF;
            state_r <= START;
          end
        end
        START: begin
          if (!sample_s) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (rx_s) begin
            // Glitch shorter than half a bit: drop it silently
            state_r <= IDLE;
          end else begin
            cnt_r   <= CNT_FULL;
            idx_r   <= {IW{1'b0}};
`ifdef UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
            state_r <= DATA;
          end
        end
        DATA: begin
          if (!sample_s) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            shreg_r[idx_r] <= rx_s;
            cnt_r          <= CNT_FULL;
            if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!sample_s) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            par_bad_r <= (rx_s != parity_expected(shreg_r));
            cnt_r     <= CNT_FULL;
            state_r   <= STOP;
          end
        end
`endif
        STOP: begin
          if (!sample_s) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (!rx_s) begin
            // Line held low: wait for release so a break is one error only
            frame_error_r  <= 1'b1;
            parity_error_r <= par_bad_s;
            state_r        <= WAIT_HIGH;
          end else begin
            // Back to IDLE mid stop bit so the next start edge is not missed
            parity_error_r <= par_bad_s;
            state_r        <= IDLE;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      level_r   <= {LW{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= push_s && full_s && !pop_s;
      if (accept_s) begin
        mem_r[wr_ptr_r] <= shreg_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({accept_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign out_data      = mem_r[rd_ptr_r];
  assign out_valid     = (level_r != {LW{1'b0}});
  assign level         = level_r;
  assign frame_error   = frame_error_r;
  assign parity_error  = parity_error_r;
  assign overrun_error = overrun_r;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed testbench for uart_rx_buffered (TICKS = 10, WIDTH = 8, DEPTH = 4).
module tb_uart_rx_buffered;

  localparam int TICKS = 10;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] level;
  logic       frame_error, parity_error, overrun_error;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, valid_cycles = 0;
  logic [7:0] popq[$];
  int base, fe0, pe0, ov0, v0;

  uart_rx_buffered #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000),
    .WIDTH     (8),
    .DEPTH     (4),
    .PARITY_ODD(0)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .rx           (rx),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .overrun_error(overrun_error)
  );

  always #5 clock = ~clock;

  // Pulse counters and pop log, sampled mid-cycle
  always @(negedge clock) begin
    if (resetn) begin
      if (frame_error)   fe_cnt++;
      if (parity_error)  pe_cnt++;
      if (overrun_error) ov_cnt++;
      if (out_valid)     valid_cycles++;
      if (out_valid && out_ready) popq.push_back(out_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] popped(input int idx);
    if (idx < popq.size()) return {24'd0, popq[idx]};
    else return 32'hDEAD_BEEF;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(TICKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bz) rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic snap();
    base = popq.size();
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; v0 = valid_cycles;
  endtask

  initial begin
    // Reset state
    resetn = 1'b0; rx = 1'b1; out_ready = 1'b1;
    idle(3);
    resetn = 1'b1;
    @(negedge clock);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_errs", {29'd0, frame_error, parity_error, overrun_error}, 32'd0);
    idle(5);

    // Single frame 0xA5
    snap();
    send_good(8'hA5);
    idle(20);
    check("a5_count", popq.size() - base, 32'd1);
    check("a5_data", popped(base), 32'hA5);
    check("a5_valid_cycles", valid_cycles - v0, 32'd1);
    check("a5_level", {29'd0, level}, 32'd0);
    check("a5_errs", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 32'd0);

    // False start of 3 cycles, then 0x5A
    snap();
    rx = 1'b0; idle(3); rx = 1'b1; idle(30);
    check("glitch_count", popq.size() - base, 32'd0);
    check("glitch_errs", (fe_cnt - fe0) + (pe_cnt - pe0), 32'd0);
    send_good(8'h5A);
    idle(20);
    check("5a_count", popq.size() - base, 32'd1);
    check("5a_data", popped(base), 32'h5A);

    // Stop bit 0 held as a break, then 0x11
    snap();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(30);
    rx = 1'b1;
    idle(30);
    check("break_fe", fe_cnt - fe0, 32'd1);
    check("break_pe", pe_cnt - pe0, 32'd0);
    check("break_count", popq.size() - base, 32'd0);
    send_good(8'h11);
    idle(20);
    check("11_count", popq.size() - base, 32'd1);
    check("11_data", popped(base), 32'h11);
    check("11_fe", fe_cnt - fe0, 32'd1);

    // Overrun: five back-to-back frames into a 4-deep FIFO
    snap();
    out_ready = 1'b0;
    for (int d = 1; d <= 5; d++) send_good(8'(d));
    idle(20);
    check("ovr_level", {29'd0, level}, 32'd4);
    check("ovr_pulse", ov_cnt - ov0, 32'd1);
    check("ovr_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_head", {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    idle(10);
    check("drain_count", popq.size() - base, 32'd4);
    check("drain_0", popped(base), 32'h01);
    check("drain_1", popped(base + 1), 32'h02);
    check("drain_2", popped(base + 2), 32'h03);
    check("drain_3", popped(base + 3), 32'h04);
    check("drain_level", {29'd0, level}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_ok_count", popq.size() - base, 32'd1);
    check("par_ok_data", popped(base), 32'h07);
    check("par_ok_pe", pe_cnt - pe0, 32'd0);
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("par_bad_count", popq.size() - base, 32'd0);
    check("par_bad_pe", pe_cnt - pe0, 32'd1);
`endif

    // Reset mid-frame with a word already queued
    out_ready = 1'b0;
    send_good(8'h99);
    idle(20);
    check("pre_rst_level", {29'd0, level}, 32'd1);
    check("pre_rst_head", {24'd0, out_data}, 32'h99);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    @(negedge clock);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_errs", {29'd0, frame_error, parity_error, overrun_error}, 32'd0);
    idle(40);
    snap();
    out_ready = 1'b1;
    send_good(8'h42);
    idle(20);
    check("42_count", popq.size() - base, 32'd1);
    check("42_data", popped(base), 32'h42);
    check("42_errs", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
